// File: rtl/decade_timer_ctrl.sv
// -----------------------------------------------------------------------------
// decade_timer_ctrl
//   Run/stop/preset controller for a cascade of DIGITS decade (BCD) counters.
//   A clock prescaler produces count ticks; the controller turns each tick into
//   per-digit enables with ripple-free carry decode. It stops counting exactly
//   when the cascade equals the BCD target and then pulses done.
//   Digit 0 is the least significant; digit i sits on bus bits [4i+3:4i].
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       start / resume request (level, sampled every cycle)
//   stop        pause request
//   clear       load all digits with 0 and return to IDLE
//   preset_we   load all digits with preset (IDLE or DONE only)
//   preset      BCD preset value
//   target      BCD stop value
//   cnt_dout    concatenated digit outputs
//   cnt_enable  per-digit count enable (combinational)
//   cnt_load    per-digit synchronous load, all bits equal (registered)
//   cnt_din     load data for the digits (registered)
//   busy        high in RUN or PAUSE
//   done        one-cycle pulse on entry to DONE
//   err         one-cycle pulse when start is rejected for a non-BCD target
// -----------------------------------------------------------------------------
module decade_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int PW       = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  preset_we,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic [4*DIGITS-1:0]   target,
    input  logic [4*DIGITS-1:0]   cnt_dout,
    output logic [DIGITS-1:0]     cnt_enable,
    output logic [DIGITS-1:0]     cnt_load,
    output logic [4*DIGITS-1:0]   cnt_din,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] LastCount = PW'(PRESCALE - 1);

    state_t                stateQ, stateD;
    logic [PW-1:0]         prescaleQ, prescaleD;
    logic                  loadQ, loadD;
    logic [4*DIGITS-1:0]   dinQ, dinD;
    logic                  doneQ, doneD;
    logic                  errQ, errD;

    logic                  tick;
    logic                  match;
    logic                  targetBad;
    logic                  carry;

    assign tick  = (prescaleQ == LastCount);
    assign match = (cnt_dout == target);

    // Any target nibble above 9 is not a reachable BCD value.
    always_comb begin
        targetBad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (target[4*i +: 4] > 4'd9) targetBad = 1'b1;
        end
    end

    // Digit i counts on a tick only when every lower digit is about to wrap
    // 9->0, so the whole cascade advances by exactly one in a single cycle.
    // A matching cascade never gets an enable, which prevents overshoot.
    always_comb begin
        cnt_enable = '0;
        carry      = (stateQ == RUN) && tick && !match;
        for (int i = 0; i < DIGITS; i++) begin
            cnt_enable[i] = carry;
            carry         = carry && (cnt_dout[4*i +: 4] == 4'd9);
        end
    end

    // Next state. Request priority is clear > stop > start > preset_we, and a
    // target match in RUN ranks just below clear so the timer never runs past
    // the target even when a pause is requested in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        stateD    = stateQ;
        prescaleD = prescaleQ;
        loadD     = 1'b0;
        dinD      = '0;
        doneD     = 1'b0;
        errD      = 1'b0;

        // The prescaler only moves in RUN, so PAUSE resumes on the same phase.
        if (stateQ == RUN) begin
            prescaleD = tick ? '0 : prescaleQ + 1'b1;
        end

        if (clear) begin
            loadD  = 1'b1;
            dinD   = '0;
            stateD = IDLE;
        end else if (stateQ == RUN && match) begin
            stateD = DONE;
            doneD  = 1'b1;
        end else if (stop) begin
            if (stateQ == RUN) stateD = PAUSE;
        end else if (start) begin
            case (stateQ)
                IDLE, DONE: begin
                    if (targetBad) begin
                        errD = 1'b1;
                    end else begin
                        stateD    = RUN;
                        prescaleD = '0;
                    end
                end
                PAUSE:   stateD = RUN;
                default: ;
            endcase
        end else if (preset_we && (stateQ == IDLE || stateQ == DONE)) begin
            loadD  = 1'b1;
            dinD   = preset;
            stateD = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= IDLE;
            prescaleQ <= '0;
            loadQ     <= 1'b0;
            dinQ      <= '0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            stateQ    <= stateD;
            prescaleQ <= prescaleD;
            loadQ     <= loadD;
            dinQ      <= dinD;
            doneQ     <= doneD;
            errQ      <= errD;
        end
    end

    assign cnt_load = {DIGITS{loadQ}};
    assign cnt_din  = dinQ;
    assign busy     = (stateQ == RUN) || (stateQ == PAUSE);
    assign done     = doneQ;
    assign err      = errQ;

endmodule
